// File: rtl/link_pkg.sv
// Shared definitions for the serial link transfer scheduler.
// Holds the FSM state encoding, the SC register field values written to
// the link port, the byte returned to a requester on an aborted transfer,
// and a helper that builds the SC word that starts a transfer.
package link_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_SB,
        ST_START,
        ST_WAIT,
        ST_READ_SB,
        ST_RESP,
        ST_ABORT
    } xfer_state_t;

    localparam logic [BYTE_W-1:0] SC_START   = 8'h80;
    localparam logic [BYTE_W-1:0] SC_INTCLK  = 8'h01;
    localparam logic [BYTE_W-1:0] SC_STOP    = 8'h00;
    localparam logic [BYTE_W-1:0] ABORT_BYTE = 8'hFF;

    // Start bit always set; internal clock selected only in master mode.
    function automatic logic [BYTE_W-1:0] sc_start_word(input logic ext_clk);
        return SC_START | (ext_clk ? SC_STOP : SC_INTCLK);
    endfunction

endpackage

// File: rtl/link_xfer_sched_if.sv
// Register-side bus between the transfer scheduler and the link port.
//   port_sel_sb / port_sel_sc : select the SB (data) or SC (control) register
//   port_we / port_re         : one-cycle write / read strobes
//   port_wdata                : write data to the port
//   port_rdata                : read data from the port
//   xfer_irq                  : one-cycle transfer-complete interrupt
// master = scheduler side, slave = link port side.
interface link_xfer_sched_if;
    import link_pkg::*;

    logic              port_sel_sb;
    logic              port_sel_sc;
    logic              port_we;
    logic              port_re;
    logic [BYTE_W-1:0] port_wdata;
    logic [BYTE_W-1:0] port_rdata;
    logic              xfer_irq;

    modport master (
        output port_sel_sb, port_sel_sc, port_we, port_re, port_wdata,
        input  port_rdata, xfer_irq
    );

    modport slave (
        input  port_sel_sb, port_sel_sc, port_we, port_re, port_wdata,
        output port_rdata, xfer_irq
    );

endinterface

// File: rtl/link_xfer_sched_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req[1:0] : pending requests
//   last     : requester granted most recently
//   gnt      : index of the winning requester (meaningful when valid)
//   valid    : at least one request pending
// A lone request always wins; on a tie the requester not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt,
    output logic       valid
);

    always_comb begin
        valid = |req;
        gnt   = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/link_xfer_sched.sv
// Two-requester scheduler for the serial link port.
// Grants one of two requesters round-robin, then sequences the byte
// exchange through the port registers: write SB, write SC to start, wait
// for the completion interrupt (bounded by a timeout), read SB back and
// return the received byte with a one-cycle done pulse.
//   cpu_clock, reset       : clock, asynchronous active-high reset
//   req[1:0]               : per-requester transfer request
//   tx_byte0 / tx_byte1    : byte to send for each requester
//   ext_clk[1:0]           : 1 = slave mode (external clock)
//   done[1:0], err         : completion pulse to the granted requester, abort flag
//   rx_byte                : received byte (ABORT_BYTE on abort)
//   busy                   : high whenever the FSM is not idle
//   bus                    : register interface to the link port
// All outputs are registered: each state's strobes are loaded on the edge
// that enters that state.
module link_xfer_sched
    import link_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int RR_INIT        = 0
) (
    input  logic              cpu_clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [BYTE_W-1:0] tx_byte0,
    input  logic [BYTE_W-1:0] tx_byte1,
    input  logic [1:0]        ext_clk,
    output logic [1:0]        done,
    output logic              err,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              busy,
    link_xfer_sched_if.master bus
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // 'last' starts on the other requester so RR_INIT wins the first tie.
    localparam logic              LAST_RST = (RR_INIT == 0) ? 1'b1 : 1'b0;

    xfer_state_t       state;
    logic              gnt_l;
    logic [BYTE_W-1:0] tx_l;
    logic              ext_l;
    logic              last;
    logic [CNT_W-1:0]  cnt;

    logic              arb_gnt;
    logic              arb_valid;
    logic [BYTE_W-1:0] arb_byte;

    // Saturating increment so the counter never wraps back under the limit.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    assign arb_byte = arb_gnt ? tx_byte1 : tx_byte0;

    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            gnt_l           <= 1'b0;
            tx_l            <= '0;
            ext_l           <= 1'b0;
            last            <= LAST_RST;
            cnt             <= '0;
            done            <= '0;
            err             <= 1'b0;
            rx_byte         <= '0;
            busy            <= 1'b0;
            bus.port_sel_sb <= 1'b0;
            bus.port_sel_sc <= 1'b0;
            bus.port_we     <= 1'b0;
            bus.port_re     <= 1'b0;
            bus.port_wdata  <= '0;
        end else begin
            // Strobes and done are single-cycle; only the entering state sets them.
            bus.port_sel_sb <= 1'b0;
            bus.port_sel_sc <= 1'b0;
            bus.port_we     <= 1'b0;
            bus.port_re     <= 1'b0;
            done            <= '0;

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_l           <= arb_gnt;
                        tx_l            <= arb_byte;
                        ext_l           <= ext_clk[arb_gnt];
                        state           <= ST_LOAD_SB;
                        busy            <= 1'b1;
                        bus.port_we     <= 1'b1;
                        bus.port_sel_sb <= 1'b1;
                        bus.port_wdata  <= arb_byte;
                    end
                end

                ST_LOAD_SB: begin
                    state           <= ST_START;
                    bus.port_we     <= 1'b1;
                    bus.port_sel_sc <= 1'b1;
                    bus.port_wdata  <= sc_start_word(ext_l);
                end

                ST_START: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end

                ST_WAIT: begin
                    cnt <= sat_inc(cnt);
                    // The interrupt is checked first so it wins over a
                    // timeout landing in the same cycle.
                    if (bus.xfer_irq) begin
                        state           <= ST_READ_SB;
                        bus.port_re     <= 1'b1;
                        bus.port_sel_sb <= 1'b1;
                    end else if (cnt >= CNT_LAST) begin
                        state           <= ST_ABORT;
                        bus.port_we     <= 1'b1;
                        bus.port_sel_sc <= 1'b1;
                        bus.port_wdata  <= SC_STOP;
                        done[gnt_l]     <= 1'b1;
                        err             <= 1'b1;
                        rx_byte         <= ABORT_BYTE;
                        last            <= gnt_l;
                    end
                end

                ST_READ_SB: begin
                    state       <= ST_RESP;
                    rx_byte     <= bus.port_rdata;
                    done[gnt_l] <= 1'b1;
                    err         <= 1'b0;
                    last        <= gnt_l;
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                ST_ABORT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    logic unused_tx;
    assign unused_tx = ^tx_l;

endmodule

// File: tb/tb_link_xfer_sched.sv
// Self-checking bench for link_xfer_sched with a short timeout.
module tb_link_xfer_sched;

    localparam int T = 16;

    logic       cpu_clock = 1'b0;
    logic       reset     = 1'b1;
    logic [1:0] req       = 2'b00;
    logic [7:0] tx_byte0  = 8'h00;
    logic [7:0] tx_byte1  = 8'h00;
    logic [1:0] ext_clk   = 2'b00;
    logic [1:0] done;
    logic       err;
    logic [7:0] rx_byte;
    logic       busy;

    link_xfer_sched_if bus ();

    link_xfer_sched #(
        .TIMEOUT_CYCLES (T),
        .RR_INIT        (0)
    ) dut (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .req       (req),
        .tx_byte0  (tx_byte0),
        .tx_byte1  (tx_byte1),
        .ext_clk   (ext_clk),
        .done      (done),
        .err       (err),
        .rx_byte   (rx_byte),
        .busy      (busy),
        .bus       (bus)
    );

    always #5 cpu_clock = ~cpu_clock;

    int cyc = 0;
    always @(posedge cpu_clock) cyc <= cyc + 1;

    int total  = 0;
    int bad    = 0;
    int last_m = 1;   // requester granted last; starts opposite RR_INIT

    // Reference arbitration rule: lone request wins, tie goes to the other one.
    function automatic int pick(input logic [1:0] r, input int lst);
        if (r == 2'b11) return 1 - lst;
        return r[1] ? 1 : 0;
    endfunction

    // Follows one transfer from its SB write to the IDLE cycle after done.
    // k = WAIT cycle (0-based) in which the irq is presented; k >= T means
    // the irq comes too late and the transfer must abort.
    // mode 0: drop req at done, 1: hold req, 2: drop req right after START.
    task automatic run_xfer(input int eg, input logic [7:0] etx, input logic eext,
                            input int k, input logic [7:0] rd, input int mode,
                            input string nm, output int sb_cyc);
        bit got;
        int s_c, dc, irqc;
        bit irq_path;
        logic [1:0] ed;
        logic [7:0] exp_sc;
        got    = 0;
        sb_cyc = -1;
        for (int t = 0; t < 20; t++) begin
            @(negedge cpu_clock);
            if (bus.port_we && bus.port_sel_sb) begin
                got = 1;
                break;
            end
        end
        bus.xfer_irq   = 1'b0;
        bus.port_rdata = rd;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s sb_write: none within 20 cycles", nm);
            return;
        end
        sb_cyc = cyc;
        total++;
        if (bus.port_wdata !== etx) begin
            bad++;
            $display("FAIL %s sb_data: got %h want %h", nm, bus.port_wdata, etx);
        end
        @(negedge cpu_clock);
        exp_sc = eext ? 8'h80 : 8'h81;
        total++;
        if (!(bus.port_we && bus.port_sel_sc && !bus.port_sel_sb) || bus.port_wdata !== exp_sc) begin
            bad++;
            $display("FAIL %s sc_write: we=%b sc=%b data=%h want %h", nm,
                     bus.port_we, bus.port_sel_sc, bus.port_wdata, exp_sc);
        end
        s_c = cyc;
        if (mode == 2) req = 2'b00;
        irq_path = (k <= T - 1);
        dc   = irq_path ? s_c + k + 3 : s_c + T + 1;
        irqc = s_c + 1 + k;
        for (int c = s_c + 1; c <= dc + 1; c++) begin
            @(negedge cpu_clock);
            ed = (c == dc) ? 2'(1 << eg) : 2'b00;
            total++;
            if (done !== ed) begin
                bad++;
                $display("FAIL %s done@%0d: got %b want %b", nm, c - s_c, done, ed);
            end
            total++;
            if (busy !== 1'(c <= dc)) begin
                bad++;
                $display("FAIL %s busy@%0d: got %b want %b", nm, c - s_c, busy, c <= dc);
            end
            if (irq_path && c == dc - 1) begin
                total++;
                if (!(bus.port_re && bus.port_sel_sb) || bus.port_we) begin
                    bad++;
                    $display("FAIL %s read_sb: re=%b sb=%b we=%b want 1 1 0", nm,
                             bus.port_re, bus.port_sel_sb, bus.port_we);
                end
            end
            if (c == dc) begin
                total++;
                if (err !== !irq_path || rx_byte !== (irq_path ? rd : 8'hFF)) begin
                    bad++;
                    $display("FAIL %s result: err=%b rx=%h want err=%b rx=%h", nm, err,
                             rx_byte, !irq_path, irq_path ? rd : 8'hFF);
                end
                if (!irq_path) begin
                    total++;
                    if (!(bus.port_we && bus.port_sel_sc) || bus.port_wdata !== 8'h00) begin
                        bad++;
                        $display("FAIL %s abort_stop: we=%b sc=%b data=%h want 1 1 00", nm,
                                 bus.port_we, bus.port_sel_sc, bus.port_wdata);
                    end
                end
                if (mode == 0) req = 2'b00;
            end
            if (c == dc + 1) begin
                total++;
                if (bus.port_we || bus.port_re || bus.port_sel_sb || bus.port_sel_sc) begin
                    bad++;
                    $display("FAIL %s idle_strobes: we=%b re=%b sb=%b sc=%b want 0", nm,
                             bus.port_we, bus.port_re, bus.port_sel_sb, bus.port_sel_sc);
                end
            end
            bus.xfer_irq = (c == irqc);
        end
        last_m = eg;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge cpu_clock);
        total++;
        if (done !== 2'b00 || err !== 1'b0 || rx_byte !== 8'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: done=%b err=%b rx=%h busy=%b want 0", done, err, rx_byte, busy);
        end
        total++;
        if (bus.port_we || bus.port_re || bus.port_sel_sb || bus.port_sel_sc || bus.port_wdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_port: we=%b re=%b sb=%b sc=%b wd=%h want 0", bus.port_we,
                     bus.port_re, bus.port_sel_sb, bus.port_sel_sc, bus.port_wdata);
        end
        reset  = 1'b0;
        last_m = 1;
        @(negedge cpu_clock);
    endtask

    task automatic test_single();
        int rc, sb;
        tx_byte0   = 8'hA5;
        ext_clk[0] = 1'b0;
        req        = 2'b01;
        rc         = cyc;
        run_xfer(pick(2'b01, last_m), 8'hA5, 1'b0, 10, 8'h3C, 0, "single", sb);
        total++;
        if (sb != rc + 1) begin
            bad++;
            $display("FAIL single_latency: sb at %0d want %0d", sb, rc + 1);
        end
    endtask

    task automatic test_min_latency();
        int rc, sb;
        tx_byte0 = 8'h5E;
        req      = 2'b01;
        rc       = cyc;
        run_xfer(0, 8'h5E, 1'b0, 0, 8'hC3, 0, "min_lat", sb);
        total++;
        if (sb != rc + 1) begin
            bad++;
            $display("FAIL min_lat_start: sb at %0d want %0d", sb, rc + 1);
        end
    endtask

    task automatic test_slave();
        int sb;
        tx_byte1   = 8'h11;
        ext_clk[1] = 1'b1;
        req        = 2'b10;
        run_xfer(pick(2'b10, last_m), 8'h11, 1'b1, 3, 8'h5A, 0, "slave", sb);
    endtask

    task automatic test_simultaneous();
        int sb, eg;
        tx_byte0 = 8'h21;
        tx_byte1 = 8'hB7;
        ext_clk  = 2'b10;
        req      = 2'b11;
        for (int i = 0; i < 4; i++) begin
            eg = pick(2'b11, last_m);
            total++;
            if (eg != (i % 2)) begin
                bad++;
                $display("FAIL simul_order: model grant %0d want %0d", eg, i % 2);
            end
            run_xfer(eg, eg ? 8'hB7 : 8'h21, ext_clk[eg], 2 + i, 8'h40 + 8'(i),
                     (i == 3) ? 0 : 1, "simul", sb);
        end
    endtask

    task automatic test_timeout();
        int sb;
        tx_byte0   = 8'h77;
        ext_clk[0] = 1'b0;
        req        = 2'b01;
        run_xfer(pick(2'b01, last_m), 8'h77, 1'b0, T + 1, 8'h99, 0, "timeout", sb);
    endtask

    task automatic test_irq_on_timeout();
        int sb;
        tx_byte1   = 8'h0F;
        ext_clk[1] = 1'b0;
        req        = 2'b10;
        run_xfer(pick(2'b10, last_m), 8'h0F, 1'b0, T - 1, 8'hE1, 0, "irq_last", sb);
    endtask

    task automatic test_req_drop();
        int sb;
        tx_byte0   = 8'h6B;
        ext_clk[0] = 1'b1;
        req        = 2'b01;
        run_xfer(pick(2'b01, last_m), 8'h6B, 1'b1, 5, 8'h2D, 2, "req_drop", sb);
    endtask

    task automatic test_reset_in_wait();
        bit got;
        int sb;
        got      = 0;
        tx_byte0 = 8'h33;
        req      = 2'b01;
        for (int t = 0; t < 20; t++) begin
            @(negedge cpu_clock);
            if (bus.port_we && bus.port_sel_sb) begin
                got = 1;
                break;
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rst_wait_start: no SB write within 20 cycles");
        end
        repeat (4) @(negedge cpu_clock);
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 2'b00 || bus.port_we || bus.port_re ||
            bus.port_sel_sb || bus.port_sel_sc) begin
            bad++;
            $display("FAIL rst_wait_async: busy=%b done=%b we=%b re=%b sb=%b sc=%b want 0",
                     busy, done, bus.port_we, bus.port_re, bus.port_sel_sb, bus.port_sel_sc);
        end
        req = 2'b00;
        @(negedge cpu_clock);
        reset  = 1'b0;
        last_m = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge cpu_clock);
            total++;
            if (done !== 2'b00 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rst_wait_quiet: done=%b busy=%b want 0 0", done, busy);
            end
        end
        tx_byte0 = 8'h44;
        tx_byte1 = 8'h55;
        ext_clk  = 2'b00;
        req      = 2'b11;
        run_xfer(pick(2'b11, last_m), 8'h44, 1'b0, 1, 8'h66, 0, "rst_wait_next", sb);
    endtask

    task automatic test_random();
        int sb, rc, eg, k;
        logic [1:0] r;
        logic [7:0] rd;
        for (int i = 0; i < 14; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge cpu_clock);
            r        = 2'($urandom_range(1, 3));
            tx_byte0 = 8'($urandom);
            tx_byte1 = 8'($urandom);
            ext_clk  = 2'($urandom);
            rd       = 8'($urandom);
            k        = $urandom_range(0, T + 1);
            eg       = pick(r, last_m);
            req      = r;
            rc       = cyc;
            run_xfer(eg, eg ? tx_byte1 : tx_byte0, ext_clk[eg], k, rd, 0, "rand", sb);
            total++;
            if (sb != rc + 1) begin
                bad++;
                $display("FAIL rand_start: sb at %0d want %0d", sb, rc + 1);
            end
        end
    endtask

    initial begin
        bus.xfer_irq   = 1'b0;
        bus.port_rdata = 8'h00;
        test_reset();
        test_single();
        test_min_latency();
        test_slave();
        test_simultaneous();
        test_timeout();
        test_irq_on_timeout();
        test_req_drop();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/link_xfer_sched.md
# link_xfer_sched

Two-requester scheduler for the serial link port. It arbitrates between the CPU-side requester (req 0) and a host/debug requester (req 1), and sequences each granted byte exchange through the port's SB/SC registers: load SB, start the transfer, wait for the completion interrupt, then read SB back. It sits between the requesters and the link port's register interface. The top level drives the shared data bus from `port_wdata` through the existing tristate wrapper.

## Interface
- `TIMEOUT_CYCLES`, default 200000: cpu_clock cycles allowed in WAIT before the transfer is aborted (about 2 byte-times at 8.2 kHz).
- `RR_INIT`, default 0: requester that wins a simultaneous first request after reset.
- `cpu_clock` in 1: the only clock; everything is posedge.
- `reset` in 1: asynchronous, active-high.
- `req[1:0]` in 2: transfer request, one bit per requester; held until `done` for that requester.
- `tx_byte0`, `tx_byte1` in 8 each: byte to send; stable while `req` is high.
- `ext_clk[1:0]` in 2: 1 = slave mode (external clock), 0 = master mode (internal clock).
- `done[1:0]` out 2: one-cycle completion pulse to the granted requester.
- `err` out 1: valid with `done`; 1 = timeout abort.
- `rx_byte` out 8: received byte, valid with `done`; 8'hFF on abort.
- `busy` out 1: high in every state except IDLE.
- `port_sel_sb`, `port_sel_sc`, `port_we`, `port_re` out 1 each: register strobes to the link port.
- `port_wdata` out 8: write data to the port.
- `port_rdata` in 8: read data from the port.
- `xfer_irq` in 1: the port's one-cycle completion interrupt.

## Operation
- States are IDLE, LOAD_SB, START, WAIT, READ_SB, RESP and ABORT.
- **IDLE:** if any `req` bit is set, grant one requester (round-robin, see below), latch `gnt`, `tx_byte[gnt]` and `ext_clk[gnt]`, then go to LOAD_SB.
- **Round-robin:** on a simultaneous request, the requester not granted last wins. `last` starts at `~RR_INIT` so that `RR_INIT` wins first. `last` updates on entry to RESP or ABORT.
- **LOAD_SB:** assert `port_we` and `port_sel_sb`, `port_wdata` = latched byte → START.
- **START:** assert `port_we` and `port_sel_sc`, `port_wdata` = {1'b1, 6'b0, ~ext_clk_l} → WAIT. Clear the timeout counter.
- **WAIT:** increment the counter each cycle.
  - `xfer_irq` → READ_SB.
  - Counter reaching `TIMEOUT_CYCLES-1` without an irq → ABORT.
  - If irq and timeout occur in the same cycle, the irq wins.
- **READ_SB:** assert `port_re` and `port_sel_sb`; capture `port_rdata` into `rx_byte` on this edge → RESP.
- **RESP:** `done[gnt]`=1, `err`=0 → IDLE.
- **ABORT:** assert `port_we` and `port_sel_sc`, `port_wdata`=8'h00 to stop the port. `done[gnt]`=1, `err`=1, `rx_byte`=8'hFF → IDLE.
- **Other cases:**
  - `xfer_irq` outside WAIT is ignored.
  - `req` dropped mid-transfer: the sequence still completes and `done` still pulses.
  - `req` still high in the cycle after `done` is treated as a new request.
- **Counter:** width is $clog2(TIMEOUT_CYCLES)+1. It saturates and never wraps.

## Timing
- All outputs are registered (Moore outputs decoded from a registered state).
- Reset values: state=IDLE, `done`=0, `err`=0, `rx_byte`=8'h00, `busy`=0, all port strobes 0, `port_wdata`=0, counter=0, `last`=~RR_INIT.
- Reset asserted mid-transfer returns the block to IDLE immediately, with no `done`. The port is reset by the same signal.
- A `req` rising at edge N puts LOAD_SB strobes on the bus in cycle N+1 and START in N+2.
- With an irq sampled at edge M, READ_SB is in cycle M+1 and `done` in cycle M+2.
- Minimum req-to-done for an immediate irq is 5 cycles.
- Back-to-back transfers: IDLE lasts at least one cycle between `done` and the next LOAD_SB.
- Each strobe is exactly one cycle wide.

## Structure
- A shared package `link_pkg` holds:
  - the state enum;
  - the SC field constants SC_START=8'h80, SC_INTCLK=8'h01, SC_STOP=8'h00;
  - the abort byte value 8'hFF.
- One sub-module, `rr_arb2`: a 2-way round-robin grant that is combinational given `req` and `last`.
- The timeout counter and FSM live in this block.

## Test plan
- **Single master transfer:** `req[0]`=1, `tx_byte0`=8'hA5, `ext_clk[0]`=0, bench irq after 10 cycles with `port_rdata`=8'h3C → SB write 8'hA5, SC write 8'h81, `done[0]` pulse, `err`=0, `rx_byte`=8'h3C.
- **Slave mode:** `ext_clk[1]`=1, `tx_byte1`=8'h11 → SC write 8'h80; response returned on `done[1]`.
- **Simultaneous requests:** `req`=2'b11 held through 4 transfers → grants alternate 0,1,0,1 (RR_INIT=0); each `done` goes only to the granted bit.
- **Timeout:** TIMEOUT_CYCLES=16, no irq → SC write 8'h00 at cycle START+17; `done` with `err`=1 and `rx_byte`=8'hFF.
- **Irq on timeout cycle:** irq coincides with the final count → READ_SB path taken, `err`=0.
- **Reset in WAIT:** assert `reset` → `busy`=0 and all strobes 0 in the same cycle; no `done`; the next `req` is granted normally.
